// File: rtl/div_pkg.sv
// Shared constants for the multi-cycle divider: state encodings,
// handshake levels and the result bus width.
package div_pkg;

  localparam int DATA_W   = 32;
  localparam int RESULT_W = 64;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/div.sv
// Restoring shift-subtract divider: 32 iterations, signed/unsigned,
// result held until the requester drops start_i.
module div
  import div_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [RESULT_W-1:0] result_o,
  output logic                ready_o
);

  localparam logic [5:0] ITERS = 6'(DATA_W);

  div_state_e          state;
  logic [5:0]          cnt;
  logic [2*DATA_W:0]   work;
  logic [DATA_W-1:0]   divisor;
  logic                sign1;
  logic                sign2;
  logic [DATA_W:0]     trial;

  function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] v,
                                                input logic en);
    return (en && v[DATA_W-1]) ? DATA_W'(~v + 1'b1) : DATA_W'(v);
  endfunction

  // Quotient negated on differing signs; remainder follows the dividend.
  function automatic logic [RESULT_W-1:0] fixup(input logic [DATA_W-1:0] quo,
                                               input logic [DATA_W-1:0] rem,
                                               input logic s1,
                                               input logic s2);
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] r;
    q = (s1 ^ s2) ? DATA_W'(~quo + 1'b1) : quo;
    r = s1 ? DATA_W'(~rem + 1'b1) : rem;
    return {r, q};
  endfunction

  assign trial = {1'b0, work[2*DATA_W-1:DATA_W]} - {1'b0, divisor};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= DivFree;
      cnt      <= '0;
      work     <= '0;
      divisor  <= '0;
      sign1    <= 1'b0;
      sign2    <= 1'b0;
      result_o <= '0;
      ready_o  <= DivResultNotReady;
    end else begin
      case (state)
        DivFree: begin
          result_o <= '0;
          ready_o  <= DivResultNotReady;
          if (start_i == DivStart && !annul_i) begin
            divisor <= abs_val(opdata2_i, signed_div_i);
            work    <= {{DATA_W{1'b0}}, abs_val(opdata1_i, signed_div_i), 1'b0};
            sign1   <= signed_div_i & opdata1_i[DATA_W-1];
            sign2   <= signed_div_i & opdata2_i[DATA_W-1];
            cnt     <= '0;
            state   <= (opdata2_i == '0) ? DivByZero : DivOn;
          end
        end
        DivByZero: begin
          if (annul_i) begin
            state <= DivFree;
          end else begin
            result_o <= '0;
            ready_o  <= DivResultReady;
            state    <= DivEnd;
          end
        end
        DivOn: begin
          if (annul_i) begin
            cnt   <= '0;
            state <= DivFree;
          end else if (cnt != ITERS) begin
            // Negative trial difference means the divisor does not fit: shift in a 0.
            if (trial[DATA_W])
              work <= {work[2*DATA_W-1:0], 1'b0};
            else
              work <= {trial[DATA_W-1:0], work[DATA_W-1:0], 1'b1};
            cnt <= cnt + 6'd1;
          end else begin
            result_o <= fixup(work[DATA_W-1:0], work[2*DATA_W:DATA_W+1], sign1, sign2);
            ready_o  <= DivResultReady;
            cnt      <= '0;
            state    <= DivEnd;
          end
        end
        DivEnd: begin
          if (start_i == DivStop) begin
            result_o <= '0;
            ready_o  <= DivResultNotReady;
            state    <= DivFree;
          end
        end
        default: state <= DivFree;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: driver queues expected results from an
// arithmetic reference model; a negedge monitor checks the DUT outputs.
module tb_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    int          acc;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a,
                                        input logic [31:0] b);
    longint x, y, qq, rr;
    logic [63:0] qv, rv;
    if (b == 0) return 64'd0;
    if (sgn) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    qq = x / y;
    rr = x % y;
    qv = qq;
    rv = rr;
    return {rv[31:0], qv[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: pop on ready rising, verify latency, hold stability and idle zeros.
  initial begin
    logic prev_ready;
    exp_t cur;
    prev_ready = 1'b0;
    cur = '{res: 64'd0, acc: 0, lat: 0};
    forever begin
      @(negedge clk);
      if (ready_o === 1'b1 && prev_ready !== 1'b1) begin
        if (q.size() == 0) begin
          check("unexpected_ready", 64'd1, 64'd0);
        end else begin
          cur = q.pop_front();
          check("result", result_o, cur.res);
          check("latency", 64'(cyc - cur.acc), 64'(cur.lat));
        end
      end else if (ready_o === 1'b1) begin
        check("hold_result", result_o, cur.res);
      end else begin
        check("idle_result_zero", result_o, 64'd0);
      end
      prev_ready = ready_o;
    end
  end

  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
    int n;
    start_op(sgn, a, b);
    q.push_back('{res: model(sgn, a, b), acc: cyc, lat: (b == 0) ? 1 : 33});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ready_o !== 1'b1 && n < 100);
    if (ready_o !== 1'b1) begin
      check("ready_timeout", 64'd0, 64'd1);
      void'(q.pop_back());
    end
    repeat (hold) @(negedge clk);
    // Operand changes while the result is held must not disturb it.
    opdata1_i = $urandom;
    opdata2_i = $urandom;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check("release_ready", 64'(ready_o), 64'd0);
    check("release_result", result_o, 64'd0);
  endtask

  initial begin
    #1;
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_div(1'b0, 32'd100, 32'd7, 0);
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, 1);
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 0);
    run_div(1'b0, 32'h12345678, 32'd0, 0);
    run_div(1'b1, 32'h87654321, 32'd0, 2);
    run_div(1'b0, 32'd100, 32'd7, 5);

    // Flush at the tenth edge after acceptance: nothing may complete.
    start_op(1'b0, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    repeat (40) @(negedge clk);
    check("annul_no_ready", 64'(ready_o), 64'd0);
    run_div(1'b0, 32'hFFFFFFFF, 32'd1, 0);

    // Annul in DIV_FREE blocks acceptance.
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b1;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    @(negedge clk);
    start_i = 1'b0;
    annul_i = 1'b0;
    repeat (40) @(negedge clk);
    check("annul_free_no_ready", 64'(ready_o), 64'd0);

    // Asynchronous reset in the middle of an iteration.
    start_op(1'b0, 32'd100, 32'd7);
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b1;
    start_i = 1'b0;
    #1;
    check("rst_mid_ready", 64'(ready_o), 64'd0);
    check("rst_mid_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_div(1'b0, 32'd100, 32'd7, 0);

    // Asynchronous reset while a result is held.
    start_op(1'b0, 32'd1000, 32'd3);
    q.push_back('{res: model(1'b0, 32'd1000, 32'd3), acc: cyc, lat: 33});
    repeat (40) @(negedge clk);
    check("pre_rst_ready", 64'(ready_o), 64'd1);
    #2;
    rst = 1'b1;
    start_i = 1'b0;
    #1;
    check("rst_end_ready", 64'(ready_o), 64'd0);
    check("rst_end_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 30; i++) begin
      logic        sgn;
      logic [31:0] a, b;
      int          mode;
      sgn  = 1'($urandom_range(0, 1));
      a    = $urandom;
      mode = $urandom_range(0, 4);
      case (mode)
        0: b = $urandom;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFFFFFF - $urandom_range(0, 7);
        3: b = $urandom & 32'h3;
        default: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      endcase
      run_div(sgn, a, b, $urandom_range(0, 3));
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
